afifo_wr_ctrl: RTL and testbench

Write-domain control half of the asynchronous FIFO. It sits directly downstream of the write driver. It accepts `winc`/`wdata` on `wclk` and generates the dual-port memory write strobe and address. It synchronises the read-domain Gray pointer, and it produces the registered `wfull`, almost-full, fill-level and overflow status that the driver and the scoreboard observe.

---
 rtl/afifo_wr_ctrl.sv | 103 ++++++++++
 tb/tb_afifo_wr_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/afifo_wr_ctrl.sv
// rtl/afifo_wr_ctrl.sv - async FIFO write-domain control: pointers, memory write port, rptr sync, full/afull/level/overflow status
// Build option: define AFIFO_WR_SYNC3_EN for a 3-flop read-pointer synchroniser (default 2 flops).
module afifo_wr_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wfull,
    output logic                  wafull,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam int PW = ADDR_WIDTH + 1;
`ifdef AFIFO_WR_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif
    localparam logic [31:0] AFULL_WORD = AFULL_LEVEL;
    localparam logic [PW-1:0] AFULL_CMP = AFULL_WORD[PW-1:0];

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic          woverflow_q, woverflow_d;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wq_rptr;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign wq_rptr   = sync_q[SYNC_STAGES-1];
    assign mem_we    = winc & ~wfull_q;
    assign mem_waddr = wbin_q[ADDR_WIDTH-1:0];
    assign mem_wdata = wdata;
    assign wptr_gray = wgray_q;
    assign wfull     = wfull_q;
    assign wafull    = wafull_q;
    assign wlevel    = wlevel_q;
    assign woverflow = woverflow_q;

    // Next-state pointers and status; a write while full is dropped so the pointers hold.
    always_comb begin
        wbin_d      = wbin_q + {{ADDR_WIDTH{1'b0}}, mem_we};
        wgray_d     = wbin_d ^ (wbin_d >> 1);
        wfull_d     = (wgray_d == {~wq_rptr[PW-1:PW-2], wq_rptr[PW-3:0]});
        wlevel_d    = wbin_d - gray2bin(wq_rptr);
        wafull_d    = (wlevel_d >= AFULL_CMP);
        woverflow_d = woverflow_q | (winc & wfull_q);
    end

    // Read-pointer synchroniser: plain flop chain, nothing between stages.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Write pointer and registered status flags.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q      <= '0;
            wgray_q     <= '0;
            wlevel_q    <= '0;
            wfull_q     <= 1'b0;
            wafull_q    <= 1'b0;
            woverflow_q <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            wgray_q     <= wgray_d;
            wlevel_q    <= wlevel_d;
            wfull_q     <= wfull_d;
            wafull_q    <= wafull_d;
            woverflow_q <= woverflow_d;
        end
    end

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// tb/tb_afifo_wr_ctrl.sv - directed self-checking bench for afifo_wr_ctrl
module tb_afifo_wr_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;
`ifdef AFIFO_WR_SYNC3_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          winc;
    logic [DW-1:0] wdata;
    logic [AW:0]   rptr_gray;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW:0]   wptr_gray;
    logic          wfull;
    logic          wafull;
    logic [AW:0]   wlevel;
    logic          woverflow;

    int tests = 0;
    int fails = 0;

    afifo_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(6)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wdata(wdata), .rptr_gray(rptr_gray),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wptr_gray(wptr_gray),
        .wfull(wfull), .wafull(wafull), .wlevel(wlevel), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [AW:0] gray(input int v);
        logic [AW:0] b;
        b = v[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wrst_n = 1'b0; winc = 1'b0; wdata = '0; rptr_gray = '0;
        #2;
        check("rst_wptr", 32'(wptr_gray), 0);
        check("rst_wfull", 32'(wfull), 0);
        check("rst_wafull", 32'(wafull), 0);
        check("rst_wlevel", 32'(wlevel), 0);
        check("rst_wovf", 32'(woverflow), 0);
        check("rst_waddr", 32'(mem_waddr), 0);
        check("rst_we", 32'(mem_we), 0);
        tick(); tick();
        wrst_n = 1'b1;
        tick();

        // Fill with eight writes
        for (int i = 0; i < 8; i++) begin
            winc = 1'b1; wdata = 8'hA0 + 8'(i);
            #1;
            check("fill_we", 32'(mem_we), 1);
            check("fill_waddr", 32'(mem_waddr), 32'(i));
            check("fill_wdata", 32'(mem_wdata), 32'(8'hA0 + 8'(i)));
            tick();
            check("fill_wlevel", 32'(wlevel), 32'(i + 1));
            check("fill_wafull", 32'(wafull), (i + 1 >= 6) ? 1 : 0);
            check("fill_wfull", 32'(wfull), (i + 1 == 8) ? 1 : 0);
        end
        check("fill_wptr", 32'(wptr_gray), 32'h0C);

        // Writes while full are dropped
        for (int i = 0; i < 2; i++) begin
            winc = 1'b1;
            #1;
            check("ovf_we", 32'(mem_we), 0);
            tick();
            check("ovf_wptr", 32'(wptr_gray), 32'h0C);
            check("ovf_wlevel", 32'(wlevel), 8);
            check("ovf_flag", 32'(woverflow), 1);
        end
        winc = 1'b0;
        tick(); tick(); tick();
        check("ovf_sticky", 32'(woverflow), 1);

        // Drain visibility: reader advances by one before edge k
        rptr_gray = 4'b0001;
        for (int e = 0; e < N; e++) begin
            tick();
            check("drain_still_full", 32'(wfull), 1);
            check("drain_still_lvl", 32'(wlevel), 8);
        end
        tick();
        check("drain_wfull", 32'(wfull), 0);
        check("drain_wlevel", 32'(wlevel), 7);
        check("drain_wafull", 32'(wafull), 1);

        // Async reset during a burst
        winc = 1'b1;
        #1;
        check("burst_we", 32'(mem_we), 1);
        check("burst_waddr", 32'(mem_waddr), 0);
        tick();
        check("burst_wfull", 32'(wfull), 1);
        tick();
        check("burst_ovf", 32'(woverflow), 1);
        check("burst_wptr", 32'(wptr_gray), 32'h0D);
        #3;
        wrst_n = 1'b0; rptr_gray = '0;
        #1;
        check("arst_wptr", 32'(wptr_gray), 0);
        check("arst_wfull", 32'(wfull), 0);
        check("arst_wafull", 32'(wafull), 0);
        check("arst_wlevel", 32'(wlevel), 0);
        check("arst_wovf", 32'(woverflow), 0);
        check("arst_waddr", 32'(mem_waddr), 0);
        check("arst_we", 32'(mem_we), 1);
        #2;
        wrst_n = 1'b1;
        #1;
        check("post_rst_waddr", 32'(mem_waddr), 0);
        tick();
        check("post_rst_wptr", 32'(wptr_gray), 32'h01);
        check("post_rst_wlevel", 32'(wlevel), 1);

        // Simultaneous write and synchronised read advance at level 5
        tick(); tick(); tick(); tick();
        check("sim_pre_lvl", 32'(wlevel), 5);
        check("sim_pre_afull", 32'(wafull), 0);
        winc = 1'b0;
        rptr_gray = 4'b0001;
        for (int e = 0; e < N; e++) begin
            tick();
            check("sim_wait_lvl", 32'(wlevel), 5);
        end
        winc = 1'b1;
        tick();
        check("sim_lvl", 32'(wlevel), 5);
        check("sim_afull", 32'(wafull), 0);
        check("sim_wptr", 32'(wptr_gray), 32'h05);
        winc = 1'b0;
        tick();
        check("sim_hold_lvl", 32'(wlevel), 5);

        // Wrap-around with a reader trailing two entries behind
        wrst_n = 1'b0; rptr_gray = '0;
        #2;
        wrst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            winc = 1'b1;
            rptr_gray = gray((i >= 2) ? i - 2 : 0);
            #1;
            check("wrap_we", 32'(mem_we), 1);
            check("wrap_waddr", 32'(mem_waddr), 32'(i % 8));
            tick();
            check("wrap_msb", 32'(wptr_gray[AW]), 32'(((i + 1) / 8) % 2));
            check("wrap_wfull", 32'(wfull), 0);
        end
        winc = 1'b0;
        check("wrap_wptr", 32'(wptr_gray), 32'(gray(20)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
